// File: rtl/step_run_ctrl.sv
// Pushbutton front end for the single-cycle processor board: synchronises and debounces
// the step/mode buttons and turns them into a one-cycle datapath clock-enable plus a pulse count.
module step_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int RUN_DIV         = 50000000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        BtnStep,
    input  logic        BtnMode,
    output logic        ClkEn,
    output logic        Running,
    output logic [15:0] StepCount
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int RW = $clog2(RUN_DIV);
    localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DIV_LAST = RW'(RUN_DIV - 1);

    typedef enum logic {
        STEP = 1'b0,
        RUN  = 1'b1
    } state_t;

    logic [1:0]    w_btn;
    logic [1:0]    r_sync1;
    logic [1:0]    r_sync2;
    logic [1:0]    r_stable;
    logic [1:0]    r_stableD;
    logic [1:0]    r_press;
    logic [DW-1:0] r_cnt [2];

    state_t        r_state;
    state_t        w_nextState;
    logic [RW-1:0] r_div;
    logic [RW-1:0] w_nextDiv;
    logic          w_nextClkEn;
    logic          r_clkEn;
    logic          r_running;
    logic [15:0]   r_stepCount;

    // Bit 0 carries the step button, bit 1 the mode button.
    assign w_btn = {BtnMode, BtnStep};

    // A level is accepted only after it differs from the accepted one for
    // DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts the count.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_stable  <= '0;
            r_stableD <= '0;
            r_press   <= '0;
            for (int b = 0; b < 2; b++) begin
                r_cnt[b] <= '0;
            end
        end else begin
            r_sync1   <= w_btn;
            r_sync2   <= r_sync1;
            r_stableD <= r_stable;
            r_press   <= r_stable & ~r_stableD;
            for (int b = 0; b < 2; b++) begin
                if (r_sync2[b] == r_stable[b]) begin
                    r_cnt[b] <= '0;
                end else if (r_cnt[b] == CNT_LAST) begin
                    r_stable[b] <= r_sync2[b];
                    r_cnt[b]    <= '0;
                end else begin
                    r_cnt[b] <= r_cnt[b] + DW'(1);
                end
            end
        end
    end

    // A mode press in RUN still lets a pulse due in the same cycle go out.
    always_comb begin
        w_nextState = r_state;
        w_nextDiv   = r_div;
        w_nextClkEn = 1'b0;
        case (r_state)
            STEP: begin
                if (r_press[1]) begin
                    w_nextState = RUN;
                    w_nextDiv   = '0;
                end else if (r_press[0]) begin
                    w_nextClkEn = 1'b1;
                end
            end
            RUN: begin
                if (r_div == DIV_LAST) begin
                    w_nextClkEn = 1'b1;
                    w_nextDiv   = '0;
                end else begin
                    w_nextDiv = r_div + RW'(1);
                end
                if (r_press[1]) begin
                    w_nextState = STEP;
                    w_nextDiv   = '0;
                end
            end
            default: begin
                w_nextState = STEP;
                w_nextDiv   = '0;
            end
        endcase
    end

    // Running tracks the next state so it changes on the same edge as the FSM.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= STEP;
            r_div       <= '0;
            r_clkEn     <= 1'b0;
            r_running   <= 1'b0;
            r_stepCount <= '0;
        end else begin
            r_state     <= w_nextState;
            r_div       <= w_nextDiv;
            r_clkEn     <= w_nextClkEn;
            r_running   <= (w_nextState == RUN);
            r_stepCount <= r_stepCount + {15'd0, r_clkEn};
        end
    end

    assign ClkEn     = r_clkEn;
    assign Running   = r_running;
    assign StepCount = r_stepCount;

endmodule

// File: tb/tb_step_run_ctrl.sv
// Directed bench for step_run_ctrl with DEBOUNCE_CYCLES=4, RUN_DIV=5; expected
// cycle positions are hand-derived from the button-to-enable latency.
module tb_step_run_ctrl;

    logic        Clk;
    logic        Reset;
    logic        BtnStep;
    logic        BtnMode;
    logic        ClkEn;
    logic        Running;
    logic [15:0] StepCount;

    int checks;
    int failures;

    step_run_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .RUN_DIV(5)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .BtnStep(BtnStep),
        .BtnMode(BtnMode),
        .ClkEn(ClkEn),
        .Running(Running),
        .StepCount(StepCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic step, input logic mode);
        BtnStep = step;
        BtnMode = mode;
    endtask

    // Steps n falling edges, counting ClkEn pulses, the index of the first and back-to-back highs.
    task automatic runWindow(input int n, output int pulses, output int first, output int doubles);
        logic prev;
        prev    = 1'b0;
        pulses  = 0;
        first   = 0;
        doubles = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge Clk);
            if (ClkEn) begin
                pulses++;
                if (first == 0) first = i;
                if (prev) doubles++;
            end
            prev = ClkEn;
        end
    endtask

    task automatic pulseReset();
        #2 Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    int pulses, first, doubles, bad, firstRun, lastPulse;

    initial begin
        checks   = 0;
        failures = 0;
        Reset    = 1'b1;
        applyStimulus(1'b0, 1'b0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        checkOutput("reset_clken", 32'(ClkEn), 32'd0);
        checkOutput("reset_running", 32'(Running), 32'd0);
        checkOutput("reset_count", 32'(StepCount), 32'd0);

        // Glitchy press: never 4 consecutive synchronised highs.
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            BtnStep = ((i < 3) || (i >= 4 && i < 7)) ? 1'b1 : 1'b0;
            @(negedge Clk);
            if (ClkEn) pulses++;
        end
        checkOutput("glitch_pulses", 32'(pulses), 32'd0);
        checkOutput("glitch_count", 32'(StepCount), 32'd0);

        applyStimulus(1'b1, 1'b0);
        runWindow(20, pulses, first, doubles);
        checkOutput("step1_pulses", 32'(pulses), 32'd1);
        checkOutput("step1_latency", 32'(first), 32'd8);
        checkOutput("step1_count", 32'(StepCount), 32'd1);
        applyStimulus(1'b0, 1'b0);
        runWindow(10, pulses, first, doubles);
        checkOutput("release_pulses", 32'(pulses), 32'd0);
        applyStimulus(1'b1, 1'b0);
        runWindow(20, pulses, first, doubles);
        checkOutput("step2_pulses", 32'(pulses), 32'd1);
        checkOutput("step2_latency", 32'(first), 32'd8);
        checkOutput("step2_count", 32'(StepCount), 32'd2);
        checkOutput("step2_running", 32'(Running), 32'd0);

        applyStimulus(1'b0, 1'b0);
        runWindow(10, pulses, first, doubles);
        #2 Reset = 1'b1;
        #1;
        checkOutput("async_reset_count", 32'(StepCount), 32'd0);
        checkOutput("async_reset_running", 32'(Running), 32'd0);
        checkOutput("async_reset_clken", 32'(ClkEn), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;

        // RUN mode: enter at edge 8, pulses at 13, 18, ... 58; step presses ignored.
        applyStimulus(1'b0, 1'b1);
        pulses   = 0;
        first    = 0;
        bad      = 0;
        firstRun = 0;
        doubles  = 0;
        for (int i = 1; i <= 60; i++) begin
            if (i == 21) BtnMode = 1'b0;
            if (i == 26) BtnStep = 1'b1;
            if (i == 46) BtnStep = 1'b0;
            @(negedge Clk);
            if (Running && firstRun == 0) firstRun = i;
            if (ClkEn) begin
                pulses++;
                if (first == 0) first = i;
                if (i < 13 || ((i - 13) % 5) != 0) bad++;
            end
        end
        checkOutput("run_enter_latency", 32'(firstRun), 32'd8);
        checkOutput("run_first_pulse", 32'(first), 32'd13);
        checkOutput("run_pulse_spacing", 32'(bad), 32'd0);
        checkOutput("run_pulses", 32'(pulses), 32'd10);
        checkOutput("run_count", 32'(StepCount), 32'd10);
        checkOutput("run_running", 32'(Running), 32'd1);

        // Mode press lands on the same cycle as a due pulse (edge 8 of this window).
        applyStimulus(1'b0, 1'b1);
        pulses    = 0;
        lastPulse = 0;
        firstRun  = 0;
        for (int j = 1; j <= 30; j++) begin
            if (j == 16) BtnMode = 1'b0;
            @(negedge Clk);
            if (!Running && firstRun == 0) firstRun = j;
            if (ClkEn) begin
                pulses++;
                lastPulse = j;
            end
        end
        checkOutput("exit_latency", 32'(firstRun), 32'd8);
        checkOutput("exit_pulses", 32'(pulses), 32'd2);
        checkOutput("exit_last_pulse", 32'(lastPulse), 32'd8);
        checkOutput("exit_count", 32'(StepCount), 32'd12);

        pulseReset();
        applyStimulus(1'b1, 1'b1);
        runWindow(10, pulses, first, doubles);
        checkOutput("both_pulses", 32'(pulses), 32'd0);
        checkOutput("both_running", 32'(Running), 32'd1);
        checkOutput("both_count", 32'(StepCount), 32'd0);
        applyStimulus(1'b0, 1'b0);
        runWindow(10, pulses, first, doubles);
        applyStimulus(1'b0, 1'b1);
        runWindow(10, pulses, first, doubles);
        checkOutput("both_exit_running", 32'(Running), 32'd0);
        applyStimulus(1'b0, 1'b0);
        runWindow(20, pulses, first, doubles);
        checkOutput("stopped_pulses", 32'(pulses), 32'd0);

        // Counter wrap: preload 0xFFFF instead of issuing 65535 real pulses.
        pulseReset();
        applyStimulus(1'b0, 1'b1);
        runWindow(8, pulses, first, doubles);
        checkOutput("wrap_running", 32'(Running), 32'd1);
        force dut.r_stepCount = 16'hFFFF;
        #1;
        release dut.r_stepCount;
        applyStimulus(1'b0, 1'b0);
        runWindow(5, pulses, first, doubles);
        checkOutput("wrap_pulse", 32'(pulses), 32'd1);
        checkOutput("wrap_preload", 32'(StepCount), 32'hFFFF);
        @(negedge Clk);
        checkOutput("wrap_zero", 32'(StepCount), 32'h0000);
        runWindow(8, pulses, first, doubles);
        checkOutput("wrap_after", 32'(StepCount), 32'd1);

        // Next pulse is due at the coming edge; reset must drop it.
        #2 Reset = 1'b1;
        #1;
        checkOutput("due_reset_count", 32'(StepCount), 32'd0);
        checkOutput("due_reset_running", 32'(Running), 32'd0);
        @(negedge Clk);
        checkOutput("due_reset_clken", 32'(ClkEn), 32'd0);
        Reset = 1'b0;
        runWindow(10, pulses, first, doubles);
        checkOutput("post_reset_pulses", 32'(pulses), 32'd0);
        checkOutput("post_reset_running", 32'(Running), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
